// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS-31 checker with BER counters.
// Optional word counter built when PRBS_CHK_WORD_CNT_EN is defined.
module prbs_chk #(
  parameter int LOCK_WORDS = 8,
  parameter int LOSS_BITS  = 8,
  parameter int LOSS_WORDS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] data_in,
  input  logic        data_valid_in,
  input  logic        clear_in,
  output logic        locked_out,
  output logic        err_flag_out,
  output logic [31:0] err_count_out,
  output logic [31:0] word_count_out
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_WORDS);
  localparam logic [6:0] LOSS_B = 7'(LOSS_BITS);
  localparam logic [7:0] LOSS_N = 8'(LOSS_WORDS);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // r[30] is the oldest bit b[n-31], r[0] the newest b[n-1]
  function automatic logic [62:0] unroll(input logic [30:0] s);
    logic [30:0] r;
    logic [31:0] w;
    logic        nb;
    r = s;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      nb   = r[30] ^ r[27];
      w[i] = nb;
      r    = {r[29:0], nb};
    end
    return {w, r};
  endfunction

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [30:0] pred;
  logic [30:0] pred_nxt;
  logic [7:0]  clean_cnt;
  logic [7:0]  clean_nxt;
  logic [7:0]  bad_run;
  logic [7:0]  bad_nxt;

  logic [62:0] roll;
  logic [31:0] exp_word;
  logic [30:0] adv;
  logic [31:0] mism;
  logic [5:0]  pc1;
  logic        bad;

  logic [31:0] mism_q;
  logic        cmp_q;
  logic [5:0]  pc2;
  logic [32:0] err_sum;
  logic [31:0] err_cnt;
  logic        err_flag;

  assign roll     = unroll(pred);
  assign exp_word = roll[62:31];
  assign adv      = roll[30:0];
  assign mism     = data_in ^ exp_word;
  assign pc1      = popcnt(mism);
  assign bad      = {1'b0, pc1} > LOSS_B;

  // Next-state logic for the sync FSM, predictor and run counters
  always_comb begin
    state_nxt = state;
    pred_nxt  = pred;
    clean_nxt = clean_cnt;
    bad_nxt   = bad_run;
    if (data_valid_in) begin
      unique case (state)
        SEARCH: begin
          pred_nxt  = data_in[30:0];
          clean_nxt = '0;
          bad_nxt   = '0;
          state_nxt = VERIFY;
        end
        VERIFY: begin
          if (mism != '0) begin
            pred_nxt  = data_in[30:0];
            clean_nxt = '0;
          end else begin
            pred_nxt = adv;
            if (clean_cnt + 8'd1 == LOCK_N) begin
              state_nxt = LOCKED;
              clean_nxt = '0;
              bad_nxt   = '0;
            end else begin
              clean_nxt = clean_cnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          pred_nxt = adv;
          if (bad) begin
            if (bad_run + 8'd1 == LOSS_N) begin
              state_nxt = SEARCH;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_run + 8'd1;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Stage 1: FSM, predictor and registered mismatch vector
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= SEARCH;
      pred      <= '0;
      clean_cnt <= '0;
      bad_run   <= '0;
      mism_q    <= '0;
      cmp_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pred      <= pred_nxt;
      clean_cnt <= clean_nxt;
      bad_run   <= bad_nxt;
      cmp_q     <= data_valid_in && (state == LOCKED);
      if (data_valid_in) mism_q <= mism;
    end
  end

  assign pc2     = popcnt(mism_q);
  assign err_sum = {1'b0, err_cnt} + {27'd0, pc2};

  // Stage 2: saturating error count and error pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      err_flag <= cmp_q && (pc2 != 6'd0);
      if (clear_in) begin
        err_cnt <= '0;
      end else if (cmp_q) begin
        err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
      end
    end
  end

`ifdef PRBS_CHK_WORD_CNT_EN
  logic [31:0] word_cnt;

  // Stage 2: saturating count of words compared in LOCKED
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_cnt <= '0;
    end else if (clear_in) begin
      word_cnt <= '0;
    end else if (cmp_q && (word_cnt != '1)) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

  assign word_count_out = word_cnt;
`else
  assign word_count_out = '0;
`endif

  assign locked_out    = (state == LOCKED);
  assign err_flag_out  = err_flag;
  assign err_count_out = err_cnt;

endmodule

// File: tb/tb_prbs_chk.sv
// tb_prbs_chk: random PRBS-31 stimulus checked against a word-level
// behavioural model, plus literal checks of the key scenarios.
module tb_prbs_chk;

  localparam int LOCK_WORDS = 8;
  localparam int LOSS_BITS  = 8;
  localparam int LOSS_WORDS = 4;
  localparam int M_SRCH = 0;
  localparam int M_VER  = 1;
  localparam int M_LCK  = 2;
`ifdef PRBS_CHK_WORD_CNT_EN
  localparam bit WCEN = 1'b1;
`else
  localparam bit WCEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        clear;
  logic        locked;
  logic        flag;
  logic [31:0] err_count;
  logic [31:0] word_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  bit gq[$];
  bit hq[$];
  bit wq[$];

  int     mode = M_SRCH;
  int     clean = 0;
  int     badrun = 0;
  bit     pend_v = 1'b0;
  int     pend_pc = 0;
  bit     m_locked = 1'b0;
  bit     m_flag = 1'b0;
  longint m_err = 0;
  longint m_wcnt = 0;

  prbs_chk dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .data_in        (data),
    .data_valid_in  (valid),
    .clear_in       (clear),
    .locked_out     (locked),
    .err_flag_out   (flag),
    .err_count_out  (err_count),
    .word_count_out (word_count)
  );

  always #5 clk = ~clk;

  // wq[0] is the oldest of the last 31 sequence bits
  function automatic logic [31:0] roll();
    logic [31:0] w;
    bit nb;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      nb = wq[0] ^ wq[3];
      wq.push_back(nb);
      void'(wq.pop_front());
      w[i] = nb;
    end
    return w;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    wq = gq;
    w = roll();
    gq = wq;
    return w;
  endfunction

  task automatic new_seed();
    bit any;
    any = 1'b0;
    gq = {};
    for (int i = 0; i < 31; i++) begin
      gq.push_back(1'($urandom_range(0, 1)));
      any = any | gq[i];
    end
    if (!any) gq[0] = 1'b1;
  endtask

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: word-level rules evaluated at each clock edge
  always @(posedge clk) begin
    logic [31:0] e;
    int pc;
    if (rst) begin
      mode = M_SRCH; hq = {}; clean = 0; badrun = 0;
      pend_v = 1'b0; m_flag = 1'b0; m_err = 0; m_wcnt = 0;
    end else begin
      m_flag = pend_v && (pend_pc != 0);
      if (clear) begin
        m_err = 0; m_wcnt = 0;
      end else if (pend_v) begin
        m_err = m_err + pend_pc;
        if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
        if (m_wcnt < 64'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
      end
      pend_v = 1'b0;
      if (valid) begin
        if (mode == M_SRCH) begin
          hq = {};
          for (int k = 30; k >= 0; k--) hq.push_back(data[k]);
          clean = 0;
          mode = M_VER;
        end else begin
          wq = hq;
          e = roll();
          hq = wq;
          if (mode == M_VER) begin
            if (e != data) begin
              hq = {};
              for (int k = 30; k >= 0; k--) hq.push_back(data[k]);
              clean = 0;
            end else begin
              clean++;
              if (clean == LOCK_WORDS) begin
                mode = M_LCK; badrun = 0;
              end
            end
          end else begin
            pc = $countones(e ^ data);
            pend_v = 1'b1;
            pend_pc = pc;
            if (pc > LOSS_BITS) begin
              badrun++;
              if (badrun == LOSS_WORDS) begin
                mode = M_SRCH; badrun = 0;
              end
            end else begin
              badrun = 0;
            end
          end
        end
      end
    end
    m_locked = (mode == M_LCK);
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked", longint'(locked), longint'(m_locked));
      check("err_flag", longint'(flag), longint'(m_flag));
      check("err_count", longint'(err_count), m_err);
      check("word_count", longint'(word_count), WCEN ? m_wcnt : 0);
      if (flag) pulses++;
    end
  end

  task automatic cyc(input bit v, input logic [31:0] w,
                     input bit clr, input bit r);
    @(negedge clk);
    #1;
    valid = v;
    data  = w;
    clear = clr;
    rst   = r;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tx(input logic [31:0] mask, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, $urandom, 1'b0, 1'b0);
    end
    cyc(1'b1, gen_word() ^ mask, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int p0, r;
    rst = 1'b1; valid = 1'b0; data = '0; clear = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(1);
    check("rst_locked", longint'(locked), 0);
    check("rst_flag", longint'(flag), 0);
    check("rst_err", longint'(err_count), 0);
    check("rst_wcnt", longint'(word_count), 0);

    gq = {};
    repeat (31) gq.push_back(1'b1);
    w = gen_word();
    check("gen_pin", longint'(w), 64'h0000_000E);

    new_seed();
    repeat (8) tx(32'h0, 1'b0);
    idle(1);
    check("lock_after_8", longint'(locked), 0);
    tx(32'h0, 1'b0);
    idle(1);
    check("lock_after_9", longint'(locked), 1);
    repeat (100) tx(32'h0, 1'b0);
    idle(2);
    check("clean_err", longint'(err_count), 0);
    check("clean_wcnt", longint'(word_count), WCEN ? 100 : 0);

    cyc(1'b1, gen_word(), 1'b0, 1'b1);
    idle(1);
    check("midrst_locked", longint'(locked), 0);
    check("midrst_flag", longint'(flag), 0);
    check("midrst_err", longint'(err_count), 0);
    check("midrst_wcnt", longint'(word_count), 0);

    new_seed();
    repeat (8) tx(32'h0, 1'b1);
    idle(1);
    check("gap_lock_8", longint'(locked), 0);
    tx(32'h0, 1'b1);
    idle(1);
    check("gap_lock_9", longint'(locked), 1);
    repeat (100) tx(32'h0, 1'b1);
    idle(2);
    check("gap_err", longint'(err_count), 0);
    check("gap_wcnt", longint'(word_count), WCEN ? 100 : 0);

    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    p0 = pulses;
    tx(32'h0000_0020, 1'b0);
    idle(1);
    check("flag_early", longint'(flag), 0);
    idle(1);
    check("flag_pulse", longint'(flag), 1);
    idle(1);
    check("bit5_err", longint'(err_count), 1);
    check("bit5_locked", longint'(locked), 1);
    check("bit5_pulses", longint'(pulses - p0), 1);
    tx(32'h0, 1'b0);
    idle(2);
    check("no_propagate", longint'(err_count), 1);

    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) tx(32'hFFFF_FFFF, 1'b0);
    tx(32'h0, 1'b0);
    idle(2);
    check("inv3_locked", longint'(locked), 1);
    check("inv3_err", longint'(err_count), 96);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) tx(32'hFFFF_FFFF, 1'b0);
    idle(2);
    check("inv4_locked", longint'(locked), 0);
    check("inv4_err", longint'(err_count), 128);
    repeat (8) tx(32'h0, 1'b0);
    idle(1);
    check("relock_8", longint'(locked), 0);
    tx(32'h0, 1'b0);
    idle(1);
    check("relock_9", longint'(locked), 1);

    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    repeat (3) tx(32'h0, 1'b0);
    tx(32'h8000_0000, 1'b0);
    repeat (7) tx(32'h0, 1'b0);
    idle(1);
    check("reseed_7", longint'(locked), 0);
    tx(32'h0, 1'b0);
    idle(1);
    check("reseed_8", longint'(locked), 1);

    idle(1);
    force dut.err_cnt = 32'hFFFF_FFF0;
    m_err = 64'hFFFF_FFF0;
    idle(1);
    release dut.err_cnt;
    tx(32'hFFFF_FFFF, 1'b0);
    idle(2);
    check("sat_err", longint'(err_count), 64'hFFFF_FFFF);
    tx(32'h0000_0001, 1'b0);
    idle(2);
    check("sat_hold", longint'(err_count), 64'hFFFF_FFFF);

    tx(32'h0000_0001, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("clr_err", longint'(err_count), 0);
    check("clr_wcnt", longint'(word_count), 0);

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        repeat (4) tx(32'hFFFF_FFFF, 1'b1);
      end else if (r < 80) begin
        tx(32'h0, 1'b1);
      end else if (r < 90) begin
        tx(32'h1 << $urandom_range(0, 31), 1'b1);
      end else if (r < 95) begin
        tx($urandom, 1'b1);
      end else begin
        cyc(1'b1, gen_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      end
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_chk.md
# prbs_chk

Parallel PRBS-31 checker for the BER tester receive path. It consumes the 32-bit words produced by `prbs_gen` after they pass through the link under test. It self-synchronises to the incoming sequence, then counts bit errors and compared words for BER computation. The counters are read by the host-side register block.

## Interface
Parameters:
- `LOCK_WORDS`, 8: consecutive error-free words in VERIFY required to enter LOCKED (range 1–255).
- `LOSS_BITS`, 8: errored bits in one word strictly above this value make the word "bad".
- `LOSS_WORDS`, 4: consecutive bad words in LOCKED that force return to SEARCH (range 1–255).

Ports:
- `clk_in`, in, 1: single clock; all logic is rising-edge.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `data_in`, in, 32: received word; bit 31 is the earliest bit in time, bit 0 the latest.
- `data_valid_in`, in, 1: `data_in` is valid this cycle.
- `clear_in`, in, 1: zero `err_count_out` and `word_count_out`.
- `locked_out`, out, 1: checker is in LOCKED.
- `err_flag_out`, out, 1: one-cycle pulse when a compared word in LOCKED had ≥1 errored bit.
- `err_count_out`, out, 32: accumulated errored bits in LOCKED, saturating.
- `word_count_out`, out, 32: accumulated compared words in LOCKED, saturating.

## Operation
- Sequence: PRBS-31, x^31 + x^28 + 1, so b[n] = b[n-31] ^ b[n-28].
- The 31-bit predictor state holds the last 31 bits of the sequence.
- Expected word: 32 bits unrolled from the state, MSB first. The state then advances by 32 bits.
- Only cycles with `data_valid_in`=1 advance any logic. Gaps freeze all state.
- FSM states:
  - SEARCH: on a valid word, load the state from `data_in[30:0]` and go to VERIFY. No comparison is made.
  - VERIFY: compare each valid word with the expected word.
    - Any mismatch: reseed from that word's `data_in[30:0]` and clear the clean counter. The state stays VERIFY.
    - Match: increment the clean counter.
    - When the clean counter reaches `LOCK_WORDS`, go to LOCKED.
  - LOCKED: the predictor free-runs from its own output and is never reseeded, so errors do not propagate.
    - popcount(`data_in` ^ expected) is added to `err_count_out`.
    - `word_count_out` is incremented.
    - A bad word (popcount > `LOSS_BITS`) increments the bad-word run. A non-bad word clears it.
    - When the run reaches `LOSS_WORDS`, go to SEARCH. The counters are kept.
- Arithmetic:
  - Popcount is 6 bits (0–32).
  - Both counters saturate at 0xFFFF_FFFF and never wrap.
- `clear_in`:
  - Zeroes both counters on the next edge.
  - It takes priority over an increment that lands in the same cycle; that word's contribution is discarded.
  - It does not affect the FSM or the predictor.
- Reset: `rst_in` takes priority over everything.
  - The FSM goes to SEARCH and the predictor, clean counter and bad-word run are cleared.
  - All outputs are 0 from the first edge after assertion, including mid-lock.

## Timing
- Stage 1 (edge N+1 after a valid word at edge N): mismatch vector registered, FSM updated, `locked_out` updated.
- Stage 2 (edge N+2): counters updated and `err_flag_out` pulsed.
- Lock entry: `locked_out` rises 1 + `LOCK_WORDS` valid words after the first valid word of a clean stream, registered at stage 1 of the last clean word.
- Lock-entry word: the word that completes VERIFY is not counted. The first counted word is the next valid one.
- Lock-loss word: the word that triggers loss of lock is still counted, because it was compared in LOCKED.
- Reset values: `locked_out`=0, `err_flag_out`=0, `err_count_out`=0, `word_count_out`=0.

## Configuration
- Macro: `PRBS_CHK_WORD_CNT_EN`.
- Defined: the `word_count_out` counter is built as described above.
- Undefined: the word counter is not built and `word_count_out` is tied to 0. Error counting and lock behaviour are unchanged.

## Test plan
- Clean acquisition: feed a continuous, error-free PRBS-31 stream from an arbitrary seed.
  - `locked_out`=1 after 9 valid words.
  - After 100 further words, `err_count_out`=0 and `word_count_out`=100.
  - Repeat with random `data_valid_in` gaps; the results must be identical.
- Single-bit error: flip bit 5 of one word while locked.
  - `err_flag_out` pulses once, 2 cycles later.
  - `err_count_out`=1 and `locked_out` stays 1.
  - The next word compares clean (no propagation).
- Loss of lock: invert 4 consecutive locked words (32 errors each).
  - `locked_out`=0 after the 4th word and `err_count_out`=128.
  - With a clean stream afterwards, lock is re-acquired after 9 words.
  - 3 inverted words followed by a clean one must keep the lock.
- VERIFY reseed: inject a 1-bit error on the 4th word of acquisition.
  - Lock is reached 8 clean words after the errored word, not before.
- Saturation and clear:
  - Preload-force `err_count_out` to 0xFFFF_FFF0, then inject 32 errors; the count must hold at 0xFFFF_FFFF.
  - Assert `clear_in` in the same cycle as an errored word's stage-2 update; both counters must read 0.
- Reset mid-lock: assert `rst_in` for 1 cycle while locked.
  - All outputs are 0 on the next edge.
  - Re-acquisition takes 9 valid words.
